// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Contents: instruction/byte widths and the 3-bit FSM state encoding.
package imem_loader_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned BYTE_W  = 8;

   typedef logic [2:0] state_t;

   localparam state_t StIdle   = 3'd0;
   localparam state_t StCntHi  = 3'd1;
   localparam state_t StCntLo  = 3'd2;
   localparam state_t StDataHi = 3'd3;
   localparam state_t StDataLo = 3'd4;
   localparam state_t StChk    = 3'd5;
   localparam state_t StDone   = 3'd6;
   localparam state_t StErr    = 3'd7;

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-pair assembler: captures the high byte of an instruction word, then on the
// low byte produces the registered {hi, lo} word together with a one-cycle valid.
// Ports:
//   Clk, Rst    - clock, synchronous active-high reset
//   hi_load     - byte_in is the high byte of a word this cycle
//   lo_load     - byte_in is the low byte of a word this cycle
//   byte_in     - stream byte
//   word        - assembled word, stable until the next lo_load
//   word_valid  - one-cycle pulse the cycle after lo_load
module imem_loader_asm
   import imem_loader_pkg::*;
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic               hi_load,
   input  logic               lo_load,
   input  logic [BYTE_W-1:0]  byte_in,
   output logic [INSTR_W-1:0] word,
   output logic               word_valid
);

   logic [BYTE_W-1:0]  hi_q;
   logic [INSTR_W-1:0] word_q;
   logic               valid_q;

   // Reset also drops a pulse already in flight so no partial load reaches memory.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         hi_q    <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= lo_load;
         if (hi_load) hi_q <= byte_in;
         if (lo_load) word_q <= {hi_q, byte_in};
      end
   end

   assign word       = word_q;
   assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader. Accepts a framed byte stream over valid/ready
// ({count_hi, count_lo, N x {hi, lo}, [chk]}), writes the N words from address 0
// and releases the CPU from reset once the image is complete.
// Optional feature macro LOADER_CHECKSUM_EN: when defined a trailing XOR checksum
// byte is required and verified; when undefined the load completes after word N.
// Ports:
//   Clk, Rst          - clock, synchronous active-high reset
//   start             - one-cycle pulse that begins a load (ignored mid-frame)
//   in_valid/in_data  - byte stream input; in_ready accepts it
//   wr_en/addr/data   - instruction memory write port
//   cpu_hold          - 1 holds the CPU in reset
//   done / error      - level status of the last load
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               start,
   input  logic               in_valid,
   input  logic [BYTE_W-1:0]  in_data,
   output logic               in_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               cpu_hold,
   output logic               done,
   output logic               error
);

`ifdef LOADER_CHECKSUM_EN
   localparam state_t StAfterData = StChk;
   logic [BYTE_W-1:0] chk_q, chk_d;
`else
   localparam state_t StAfterData = StDone;
`endif

   state_t            state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [15:0]       wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       count_full;
   logic              accept;
   logic              hi_load;
   logic              lo_load;
   logic              last_word;

   assign in_ready   = (state_q >= StCntHi) && (state_q <= StChk);
   assign accept     = in_valid && in_ready;
   assign hi_load    = accept && (state_q == StDataHi);
   assign lo_load    = accept && (state_q == StDataLo);
   assign count_full = {count_q[15:8], in_data};
   assign last_word  = (wcnt_q + 16'd1) == count_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
`ifdef LOADER_CHECKSUM_EN
      chk_d   = chk_q;
      if (accept) chk_d = chk_q ^ in_data;
`endif
      case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StCntHi;
               wcnt_d  = '0;
               addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
               chk_d   = '0;
`endif
            end
         end
         StCntHi: begin
            if (accept) begin
               count_d[15:8] = in_data;
               state_d       = StCntLo;
            end
         end
         StCntLo: begin
            if (accept) begin
               count_d = count_full;
               if (32'(count_full) > DEPTH) state_d = StErr;
               else if (count_full == 16'd0) state_d = StAfterData;
               else                          state_d = StDataHi;
            end
         end
         StDataHi: begin
            if (accept) state_d = StDataLo;
         end
         StDataLo: begin
            if (accept) begin
               // Address is captured with the word; wr_en follows one cycle later.
               addr_d  = ADDR_W'(wcnt_q);
               wcnt_d  = wcnt_q + 16'd1;
               state_d = last_word ? StAfterData : StDataHi;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         StChk: begin
            // chk_q here excludes the checksum byte itself.
            if (accept) state_d = (in_data == chk_q) ? StDone : StErr;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= StIdle;
         count_q <= '0;
         wcnt_q  <= '0;
         addr_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

   imem_loader_asm u_asm (
      .Clk        (Clk),
      .Rst        (Rst),
      .hi_load    (hi_load),
      .lo_load    (lo_load),
      .byte_in    (in_data),
      .word       (wr_data),
      .word_valid (wr_en)
   );

   assign wr_addr  = addr_q;
   assign done     = (state_q == StDone);
   assign error    = (state_q == StErr);
   assign cpu_hold = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 256;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  frame[$];
   logic [23:0] exp_wr[$];
   logic [23:0] got_wr[$];
   int          exp_len;
   int          exp_ok;      // 1: load should end in done, 0: in error
   int          acc_cnt = 0;

   // Observe the write port and byte consumption away from the active edge.
   always @(negedge Clk) begin
      if (wr_en) got_wr.push_back({wr_addr, wr_data});
      if (in_valid && in_ready) acc_cnt++;
   end

   // Reference: parse the frame by its format rules.
   task automatic model();
      int n;
      logic [7:0] x;
      exp_wr.delete();
      n = int'({frame[0], frame[1]});
      if (n > int'(DEPTH)) begin
         exp_ok  = 0;
         exp_len = 2;
         return;
      end
      exp_len = 2 + 2 * n;
      for (int i = 0; i < n; i++)
         exp_wr.push_back({8'(i), frame[2 + 2 * i], frame[3 + 2 * i]});
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int j = 0; j < exp_len; j++) x = x ^ frame[j];
      exp_ok  = (frame[exp_len] == x) ? 1 : 0;
      exp_len = exp_len + 1;
`else
      x = 8'h00;
      exp_ok = (x == 8'h00) ? 1 : 0;
`endif
   endtask

   task automatic add_chk(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      foreach (frame[j]) x = x ^ frame[j];
      frame.push_back(x ^ {7'b0, corrupt});
`else
      if (corrupt) frame.push_back(8'h00);
      else frame.push_back(8'h00);
      void'(frame.pop_back());
`endif
   endtask

   task automatic build_frame(input int n, input bit corrupt);
      logic [15:0] nn;
      nn = 16'(n);
      frame.delete();
      frame.push_back(nn[15:8]);
      frame.push_back(nn[7:0]);
      if (n <= int'(DEPTH)) begin
         for (int i = 0; i < 2 * n; i++) frame.push_back(8'($urandom));
         add_chk(corrupt);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
      bit ok;
      ok = 1'b0;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge Clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge Clk);
         ok = in_ready;
         if (noise && ok && $urandom_range(3, 0) == 0) start = 1'b1;
         @(posedge Clk); #1;
         start = 1'b0;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         $display("FAIL handshake_timeout: byte %02h never accepted, want accept", b);
      end
   endtask

   task automatic run_frame(input string name, input int gapmax, input bit noise,
                            input bit chk_start);
      int base_wr, base_acc, n_got;
      model();
      base_wr  = got_wr.size();
      base_acc = acc_cnt;
      pulse_start();
      if (chk_start) begin
         @(negedge Clk);
         n_checks++;
         if ({done, error, cpu_hold, in_ready} !== 4'b0011)
            $display("FAIL %s_restart: done/err/hold/rdy got %b want 0011", name,
                     {done, error, cpu_hold, in_ready});
         else n_pass++;
         @(posedge Clk); #1;
      end
      for (int k = 0; k < exp_len; k++)
         send_byte(frame[k], $urandom_range(gapmax, 0), noise);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if ({done, error, cpu_hold, in_ready} !==
          {exp_ok == 1, exp_ok == 0, exp_ok == 0, 1'b0})
         $display("FAIL %s_status: done/err/hold/rdy got %b want %b", name,
                  {done, error, cpu_hold, in_ready},
                  {exp_ok == 1, exp_ok == 0, exp_ok == 0, 1'b0});
      else n_pass++;
      n_checks++;
      if (acc_cnt - base_acc !== exp_len)
         $display("FAIL %s_consumed: got %0d bytes want %0d", name, acc_cnt - base_acc,
                  exp_len);
      else n_pass++;
      n_got = got_wr.size() - base_wr;
      n_checks++;
      if (n_got !== exp_wr.size())
         $display("FAIL %s_nwrites: got %0d want %0d", name, n_got, exp_wr.size());
      else n_pass++;
      for (int i = 0; i < exp_wr.size() && i < n_got; i++) begin
         n_checks++;
         if (got_wr[base_wr + i] !== exp_wr[i])
            $display("FAIL %s_write%0d: got addr/data %06h want %06h", name, i,
                     got_wr[base_wr + i], exp_wr[i]);
         else n_pass++;
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_reset();
      Rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      @(negedge Clk);
      n_checks++;
      if ({wr_en, done, error, cpu_hold, in_ready} !== 5'b00010)
         $display("FAIL reset_ctrl: en/done/err/hold/rdy got %b want 00010",
                  {wr_en, done, error, cpu_hold, in_ready});
      else n_pass++;
      n_checks++;
      if ({wr_addr, wr_data} !== 24'h0)
         $display("FAIL reset_port: got %06h want 000000", {wr_addr, wr_data});
      else n_pass++;
      @(posedge Clk); #1;
   endtask

   task automatic test_basic();
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      add_chk(1'b0);
      run_frame("basic", 0, 1'b0, 1'b0);
   endtask

   task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      add_chk(1'b1);
      run_frame("badchk", 0, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_oversize();
      frame = '{8'h01, 8'h01};
      run_frame("oversize", 0, 1'b0, 1'b0);
   endtask

   task automatic test_zero_gaps();
      frame = '{8'h00, 8'h00};
      add_chk(1'b0);
      run_frame("zero", 3, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int base_wr;
      base_wr = got_wr.size();
      pulse_start();
      frame = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
      foreach (frame[k]) send_byte(frame[k], 0, 1'b0);
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      n_checks++;
      if ({wr_en, done, error, cpu_hold, in_ready} !== 5'b00010)
         $display("FAIL rstmid_ctrl: en/done/err/hold/rdy got %b want 00010",
                  {wr_en, done, error, cpu_hold, in_ready});
      else n_pass++;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if (got_wr.size() - base_wr !== 1)
         $display("FAIL rstmid_nwrites: got %0d want 1", got_wr.size() - base_wr);
      else n_pass++;
      n_checks++;
      if (got_wr[got_wr.size() - 1] !== 24'h00_1122)
         $display("FAIL rstmid_word: got %06h want 001122", got_wr[got_wr.size() - 1]);
      else n_pass++;
      @(posedge Clk); #1;
      build_frame(3, 1'b0);
      run_frame("rstmid_reload", 1, 1'b0, 1'b0);
   endtask

   task automatic test_reload();
      build_frame(2, 1'b0);
      run_frame("predone", 0, 1'b0, 1'b0);
      frame = '{8'h00, 8'h01, 8'h5A, 8'hA5};
      add_chk(1'b0);
      run_frame("reload", 0, 1'b1, 1'b1);
   endtask

   task automatic test_full_depth();
      build_frame(int'(DEPTH), 1'b0);
      run_frame("fulldepth", 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 15; f++) begin
         if ($urandom_range(7, 0) == 0) n = int'(DEPTH) + 1 + int'($urandom_range(100, 0));
         else n = int'($urandom_range(6, 0));
         build_frame(n, $urandom_range(3, 0) == 0);
         run_frame("random", 2, 1'b1, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_checksum();
      test_oversize();
      test_zero_gaps();
      test_reset_mid();
      test_reload();
      test_full_depth();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
